// File: rtl/showcase_ram_arbiter.sv
// rtl/showcase_ram_arbiter.sv - Round-robin two-port arbiter owning a small scratch RAM
// Optional build macro: SHOWCASE_RAM_ARB_STATS_EN adds per-port 16-bit saturating grant counters.
module showcase_ram_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_0_valid,
  output logic                  req_0_ready,
  input  logic                  req_0_we,
  input  logic [ADDR_WIDTH-1:0] req_0_addr,
  input  logic [DATA_WIDTH-1:0] req_0_wdata,
  input  logic                  req_0_lock,
  input  logic                  req_1_valid,
  output logic                  req_1_ready,
  input  logic                  req_1_we,
  input  logic [ADDR_WIDTH-1:0] req_1_addr,
  input  logic [DATA_WIDTH-1:0] req_1_wdata,
  input  logic                  req_1_lock,
  output logic                  rsp_0_valid,
  output logic [DATA_WIDTH-1:0] rsp_0_data,
  output logic                  rsp_1_valid,
  output logic [DATA_WIDTH-1:0] rsp_1_data
`ifdef SHOWCASE_RAM_ARB_STATS_EN
  ,
  output logic [15:0]           grant_cnt_0,
  output logic [15:0]           grant_cnt_1
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_last;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_rd0;
  logic                  w_rd1;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_rsp_0_valid;
  logic                  r_rsp_1_valid;
  logic [DATA_WIDTH-1:0] r_rsp_0_data;
  logic [DATA_WIDTH-1:0] r_rsp_1_data;

  // State register: arbitration mode, reset drops any lock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: an accepted beat either takes/keeps the lock or releases it
  always_comb begin
    w_state_nxt = r_state;
    if (w_gnt0) begin
      w_state_nxt = req_0_lock ? LOCK0 : IDLE;
    end else if (w_gnt1) begin
      w_state_nxt = req_1_lock ? LOCK1 : IDLE;
    end
  end

  // Grant decision: round-robin in IDLE, owner-only while locked
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_state)
      IDLE: begin
        // On contention the port that was not served last wins
        w_gnt0 = req_0_valid & (~req_1_valid | r_last);
        w_gnt1 = req_1_valid & (~req_0_valid | ~r_last);
      end
      LOCK0:   w_gnt0 = req_0_valid;
      LOCK1:   w_gnt1 = req_1_valid;
      default: ;
    endcase
  end

  assign req_0_ready = w_gnt0;
  assign req_1_ready = w_gnt1;
  assign w_rd0       = w_gnt0 & ~req_0_we;
  assign w_rd1       = w_gnt1 & ~req_1_we;

  // Last-granted index; reset to 1 so port 0 wins the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (w_gnt0) begin
      r_last <= 1'b0;
    end else if (w_gnt1) begin
      r_last <= 1'b1;
    end
  end

  // RAM write port: contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (w_gnt0 && req_0_we) begin
      r_mem[req_0_addr] <= req_0_wdata;
    end else if (w_gnt1 && req_1_we) begin
      r_mem[req_1_addr] <= req_1_wdata;
    end
  end

  // Read responses: one-cycle valid pulse, data held until the next read on that port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_0_valid <= 1'b0;
      r_rsp_1_valid <= 1'b0;
      r_rsp_0_data  <= '0;
      r_rsp_1_data  <= '0;
    end else begin
      r_rsp_0_valid <= w_rd0;
      r_rsp_1_valid <= w_rd1;
      if (w_rd0) begin
        r_rsp_0_data <= r_mem[req_0_addr];
      end
      if (w_rd1) begin
        r_rsp_1_data <= r_mem[req_1_addr];
      end
    end
  end

  assign rsp_0_valid = r_rsp_0_valid;
  assign rsp_1_valid = r_rsp_1_valid;
  assign rsp_0_data  = r_rsp_0_data;
  assign rsp_1_data  = r_rsp_1_data;

`ifdef SHOWCASE_RAM_ARB_STATS_EN
  logic [15:0] r_grant_cnt_0;
  logic [15:0] r_grant_cnt_1;

  // Accepted-beat counters, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant_cnt_0 <= '0;
      r_grant_cnt_1 <= '0;
    end else begin
      if (w_gnt0 && (r_grant_cnt_0 != 16'hFFFF)) begin
        r_grant_cnt_0 <= r_grant_cnt_0 + 16'd1;
      end
      if (w_gnt1 && (r_grant_cnt_1 != 16'hFFFF)) begin
        r_grant_cnt_1 <= r_grant_cnt_1 + 16'd1;
      end
    end
  end

  assign grant_cnt_0 = r_grant_cnt_0;
  assign grant_cnt_1 = r_grant_cnt_1;
`else
  // Statistics disabled: no counters are built and arbitration is unchanged.
`endif

endmodule

// File: tb/tb_showcase_ram_arbiter.sv
// tb/tb_showcase_ram_arbiter.sv - Directed self-checking bench for showcase_ram_arbiter
module tb_showcase_ram_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req_0_valid, req_0_we, req_0_lock;
  logic [1:0] req_0_addr;
  logic [7:0] req_0_wdata;
  logic       req_1_valid, req_1_we, req_1_lock;
  logic [1:0] req_1_addr;
  logic [7:0] req_1_wdata;
  logic       req_0_ready, req_1_ready;
  logic       rsp_0_valid, rsp_1_valid;
  logic [7:0] rsp_0_data, rsp_1_data;
`ifdef SHOWCASE_RAM_ARB_STATS_EN
  logic [15:0] grant_cnt_0, grant_cnt_1;
`endif

  int checks;
  int errors;

  showcase_ram_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_0_valid (req_0_valid),
    .req_0_ready (req_0_ready),
    .req_0_we    (req_0_we),
    .req_0_addr  (req_0_addr),
    .req_0_wdata (req_0_wdata),
    .req_0_lock  (req_0_lock),
    .req_1_valid (req_1_valid),
    .req_1_ready (req_1_ready),
    .req_1_we    (req_1_we),
    .req_1_addr  (req_1_addr),
    .req_1_wdata (req_1_wdata),
    .req_1_lock  (req_1_lock),
    .rsp_0_valid (rsp_0_valid),
    .rsp_0_data  (rsp_0_data),
    .rsp_1_valid (rsp_1_valid),
    .rsp_1_data  (rsp_1_data)
`ifdef SHOWCASE_RAM_ARB_STATS_EN
    ,
    .grant_cnt_0 (grant_cnt_0),
    .grant_cnt_1 (grant_cnt_1)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_0_valid = 0; req_0_we = 0; req_0_lock = 0; req_0_addr = 0; req_0_wdata = 0;
    req_1_valid = 0; req_1_we = 0; req_1_lock = 0; req_1_addr = 0; req_1_wdata = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    do_reset();

    // Reset state
    chk("rst_rsp0_valid", {15'd0, rsp_0_valid}, 16'd0);
    chk("rst_rsp0_data", {8'd0, rsp_0_data}, 16'd0);
    chk("rst_rsp1_valid", {15'd0, rsp_1_valid}, 16'd0);
    chk("rst_rsp1_data", {8'd0, rsp_1_data}, 16'd0);
    chk("rst_ready0", {15'd0, req_0_ready}, 16'd0);
    chk("rst_ready1", {15'd0, req_1_ready}, 16'd0);

    // Port 0 writes 0x5A to addr 2 then reads it back
    req_0_valid = 1; req_0_we = 1; req_0_addr = 2'd2; req_0_wdata = 8'h5A;
    #1;
    chk("wr_ready0", {15'd0, req_0_ready}, 16'd1);
    chk("wr_ready1", {15'd0, req_1_ready}, 16'd0);
    tick();
    chk("wr_no_rsp0", {15'd0, rsp_0_valid}, 16'd0);
    req_0_we = 0;
    #1;
    chk("rd_ready0", {15'd0, req_0_ready}, 16'd1);
    tick();
    req_0_valid = 0;
    chk("rd_rsp0_valid", {15'd0, rsp_0_valid}, 16'd1);
    chk("rd_rsp0_data", {8'd0, rsp_0_data}, 16'h005A);
    chk("rd_rsp1_quiet", {15'd0, rsp_1_valid}, 16'd0);
    tick();
    chk("rd_rsp0_pulse_end", {15'd0, rsp_0_valid}, 16'd0);
    chk("rd_rsp0_hold", {8'd0, rsp_0_data}, 16'h005A);

    // Preload addr 0 = 0x11, addr 1 = 0x22, addr 3 = 0x33 (RAM survives reset)
    req_0_valid = 1; req_0_we = 1; req_0_addr = 2'd0; req_0_wdata = 8'h11;
    tick();
    req_0_addr = 2'd1; req_0_wdata = 8'h22;
    tick();
    req_0_addr = 2'd3; req_0_wdata = 8'h33;
    tick();
    idle_inputs();

    // Continuous contention from reset: grants alternate 0,1,0,1
    do_reset();
    req_0_valid = 1; req_0_addr = 2'd0;
    req_1_valid = 1; req_1_addr = 2'd1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("rr_ready0_%0d", i), {15'd0, req_0_ready}, (i % 2 == 0) ? 16'd1 : 16'd0);
      chk($sformatf("rr_ready1_%0d", i), {15'd0, req_1_ready}, (i % 2 == 1) ? 16'd1 : 16'd0);
      tick();
      if (i == 3) idle_inputs();
      chk($sformatf("rr_rsp0_%0d", i), {15'd0, rsp_0_valid}, (i % 2 == 0) ? 16'd1 : 16'd0);
      chk($sformatf("rr_rsp1_%0d", i), {15'd0, rsp_1_valid}, (i % 2 == 1) ? 16'd1 : 16'd0);
      if (i % 2 == 0) chk($sformatf("rr_data0_%0d", i), {8'd0, rsp_0_data}, 16'h0011);
      else            chk($sformatf("rr_data1_%0d", i), {8'd0, rsp_1_data}, 16'h0022);
    end

    // Port 0 locked burst of three writes while port 1 waits
    req_1_valid = 1; req_1_addr = 2'd3; req_1_lock = 1;
    req_0_valid = 1; req_0_we = 1; req_0_addr = 2'd3;
    for (int i = 0; i < 3; i++) begin
      req_0_wdata = 8'hA0 + 8'(i);
      req_0_lock  = (i < 2);
      #1;
      chk($sformatf("lk_ready0_%0d", i), {15'd0, req_0_ready}, 16'd1);
      chk($sformatf("lk_ready1_%0d", i), {15'd0, req_1_ready}, 16'd0);
      tick();
    end
    req_0_valid = 0; req_0_we = 0; req_0_lock = 0;
    #1;
    chk("lk_ready1_after", {15'd0, req_1_ready}, 16'd1);
    tick();
    chk("lk_rsp1_valid", {15'd0, rsp_1_valid}, 16'd1);
    chk("lk_rsp1_data", {8'd0, rsp_1_data}, 16'h00A2);

    // Now in LOCK1: owner idles two cycles, port 0 must not be granted
    req_1_valid = 0; req_1_lock = 0;
    req_0_valid = 1; req_0_addr = 2'd0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("l1_ready0_%0d", i), {15'd0, req_0_ready}, 16'd0);
      chk($sformatf("l1_ready1_%0d", i), {15'd0, req_1_ready}, 16'd0);
      tick();
    end
    req_1_valid = 1; req_1_addr = 2'd1;
    #1;
    chk("l1_resume_ready1", {15'd0, req_1_ready}, 16'd1);
    chk("l1_resume_ready0", {15'd0, req_0_ready}, 16'd0);
    tick();
    req_1_valid = 0;
    chk("l1_rsp1_data", {8'd0, rsp_1_data}, 16'h0022);
    #1;
    chk("l1_after_ready0", {15'd0, req_0_ready}, 16'd1);
    tick();
    chk("l1_rsp0_data", {8'd0, rsp_0_data}, 16'h0011);

    // Asynchronous reset in LOCK0 with a read response pending
    req_0_addr = 2'd3; req_0_lock = 1;
    tick();
    chk("ar_rsp0_pending", {15'd0, rsp_0_valid}, 16'd1);
    chk("ar_rsp0_data", {8'd0, rsp_0_data}, 16'h00A2);
    req_0_valid = 0; req_0_lock = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_rsp0_cleared", {15'd0, rsp_0_valid}, 16'd0);
    chk("ar_rsp0_data_cleared", {8'd0, rsp_0_data}, 16'd0);
    tick();
    #2;
    rst_n = 1'b1;
    req_1_valid = 1; req_1_addr = 2'd1;
    #1;
    chk("ar_ready1", {15'd0, req_1_ready}, 16'd1);
    chk("ar_ready0", {15'd0, req_0_ready}, 16'd0);
    tick();
    req_1_valid = 0;
    chk("ar_rsp1_valid", {15'd0, rsp_1_valid}, 16'd1);
    chk("ar_rsp1_data", {8'd0, rsp_1_data}, 16'h0022);

`ifdef SHOWCASE_RAM_ARB_STATS_EN
    // Five accepted beats from port 1 after a fresh reset
    idle_inputs();
    do_reset();
    chk("st_cnt1_reset", grant_cnt_1, 16'd0);
    req_1_valid = 1; req_1_we = 1; req_1_addr = 2'd2; req_1_wdata = 8'h77;
    for (int i = 0; i < 5; i++) tick();
    idle_inputs();
    tick();
    chk("st_cnt1", grant_cnt_1, 16'd5);
    chk("st_cnt0", grant_cnt_0, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
